// File: rtl/demux1x2_stream.sv
// demux1x2_stream: registered 1-to-2 stream demux with a one-entry holding register per output.
// Build macro DEMUX_CNT_EN adds per-output delivered-word counters (A_Cnt/B_Cnt).
module demux1x2_stream #(
    parameter int DATAWIDTH = 8
`ifdef DEMUX_CNT_EN
    , parameter int CNTWIDTH = 16
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] In_D,
    input  logic                 In_Sel,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [DATAWIDTH-1:0] A_D,
    output logic                 A_Valid,
    input  logic                 A_Ready,
    output logic [DATAWIDTH-1:0] B_D,
    output logic                 B_Valid,
    input  logic                 B_Ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNTWIDTH-1:0]  A_Cnt,
    output logic [CNTWIDTH-1:0]  B_Cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Index 0 is side A (In_Sel=1), index 1 is side B (In_Sel=0).
    logic                 side_sel       [2];
    logic                 side_out_ready [2];
    logic                 side_can_take  [2];
    logic                 side_full      [2];
    logic [DATAWIDTH-1:0] side_data      [2];
`ifdef DEMUX_CNT_EN
    logic [CNTWIDTH-1:0]  side_cnt       [2];
`endif
    logic                 in_xfer;

    assign side_sel[0]       = In_Sel;
    assign side_sel[1]       = ~In_Sel;
    assign side_out_ready[0] = A_Ready;
    assign side_out_ready[1] = B_Ready;

    // Only the addressed side can stall the producer; In_Valid is deliberately excluded.
    assign In_Ready = In_Sel ? side_can_take[0] : side_can_take[1];
    assign in_xfer  = In_Valid & In_Ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic [0:0]           state_reg;
            logic [0:0]           state_next;
            logic [DATAWIDTH-1:0] data_reg;
            logic [DATAWIDTH-1:0] data_next;
            logic                 load;
            logic                 take;

            assign load = in_xfer & side_sel[gi];
            assign take = (state_reg == ST_FULL) & side_out_ready[gi];

            // A full slot can accept a new word in the same cycle it is drained.
            assign side_can_take[gi] = (state_reg == ST_EMPTY) | side_out_ready[gi];

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_EMPTY: if (load) state_next = ST_FULL;
                    default:  if (take && !load) state_next = ST_EMPTY;
                endcase
            end

            assign data_next = load ? In_D : data_reg;

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    state_reg <= ST_EMPTY;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    data_reg  <= data_next;
                end
            end

            assign side_full[gi] = (state_reg == ST_FULL);
            assign side_data[gi] = data_reg;

`ifdef DEMUX_CNT_EN
            logic [CNTWIDTH-1:0] cnt_reg;

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    cnt_reg <= '0;
                end else if (take) begin
                    cnt_reg <= cnt_reg + CNTWIDTH'(1);
                end
            end

            assign side_cnt[gi] = cnt_reg;
`endif
        end
    endgenerate

    assign A_Valid = side_full[0];
    assign A_D     = side_data[0];
    assign B_Valid = side_full[1];
    assign B_D     = side_data[1];
`ifdef DEMUX_CNT_EN
    assign A_Cnt   = side_cnt[0];
    assign B_Cnt   = side_cnt[1];
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Directed, table-driven bench for demux1x2_stream; counter checks run when DEMUX_CNT_EN is defined.
module tb_demux1x2_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_d;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_d;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_d;
    logic       b_valid;
    logic       b_ready;
`ifdef DEMUX_CNT_EN
    logic [3:0] a_cnt;
    logic [3:0] b_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    demux1x2_stream #(
        .DATAWIDTH(8)
`ifdef DEMUX_CNT_EN
        , .CNTWIDTH(4)
`endif
    ) dut (
        .Clk     (clk),
        .Rst     (rst_n),
        .In_D    (in_d),
        .In_Sel  (in_sel),
        .In_Valid(in_valid),
        .In_Ready(in_ready),
        .A_D     (a_d),
        .A_Valid (a_valid),
        .A_Ready (a_ready),
        .B_D     (b_d),
        .B_Valid (b_valid),
        .B_Ready (b_ready)
`ifdef DEMUX_CNT_EN
        ,
        .A_Cnt   (a_cnt),
        .B_Cnt   (b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [7:0] d;
        logic       valid;
        logic       ar;
        logic       br;
        logic       exp_rdy;
        logic       exp_av;
        logic [7:0] exp_ad;
        logic       exp_bv;
        logic [7:0] exp_bd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [7:0] d, input logic valid,
                         input logic ar, input logic br);
        in_sel   = sel;
        in_d     = d;
        in_valid = valid;
        a_ready  = ar;
        b_ready  = br;
    endtask

    logic [7:0] got_a [$];
    logic [7:0] got_b [$];

    initial begin
        // sel, d, valid, A_Ready, B_Ready | In_Ready, then A_Valid/A_D, B_Valid/B_D after the edge
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 8'h11};
        vecs[6]  = '{1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 8'h11};
        vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h11};
        vecs[8]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h11};
        vecs[9]  = '{1'b0, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'h11};
        vecs[10] = '{1'b0, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 8'h66};
        vecs[11] = '{1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'h66};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_a_valid", 16'(a_valid), 16'h0);
        chk("reset_b_valid", 16'(b_valid), 16'h0);
        chk("reset_a_d", 16'(a_d), 16'h00);
        chk("reset_b_d", 16'(b_d), 16'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sel, vecs[i].d, vecs[i].valid, vecs[i].ar, vecs[i].br);
            #1;
            chk($sformatf("v%0d_in_ready", i), 16'(in_ready), 16'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            $display("vec %0d: sel=%0b d=%02h valid=%0b ar=%0b br=%0b -> A %0b/%02h B %0b/%02h",
                     i, vecs[i].sel, vecs[i].d, vecs[i].valid, vecs[i].ar, vecs[i].br,
                     a_valid, a_d, b_valid, b_d);
            chk($sformatf("v%0d_a_valid", i), 16'(a_valid), 16'(vecs[i].exp_av));
            chk($sformatf("v%0d_a_d", i), 16'(a_d), 16'(vecs[i].exp_ad));
            chk($sformatf("v%0d_b_valid", i), 16'(b_valid), 16'(vecs[i].exp_bv));
            chk($sformatf("v%0d_b_d", i), 16'(b_d), 16'(vecs[i].exp_bd));
        end

        // Alternating stream, both consumers always ready: one word per cycle, in order per side.
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) == 0, 8'(8'h80 + i), 1'b1, 1'b1, 1'b1);
            #1;
            chk($sformatf("stream%0d_in_ready", i), 16'(in_ready), 16'h1);
            @(posedge clk);
            #1;
            if (a_valid) got_a.push_back(a_d);
            if (b_valid) got_b.push_back(b_d);
            $display("stream %0d: word %02h -> A %0b/%02h B %0b/%02h",
                     i, 8'(8'h80 + i), a_valid, a_d, b_valid, b_d);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("stream_drain_a_valid", 16'(a_valid), 16'h0);
        chk("stream_drain_b_valid", 16'(b_valid), 16'h0);
        chk("stream_a_count", 16'(got_a.size()), 16'd5);
        chk("stream_b_count", 16'(got_b.size()), 16'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_a.size()) chk($sformatf("stream_a%0d", k), 16'(got_a[k]), 16'(8'h80 + 2 * k));
            if (k < got_b.size()) chk($sformatf("stream_b%0d", k), 16'(got_b[k]), 16'(8'h81 + 2 * k));
        end

        // Asynchronous reset while A holds 8'h5A: must clear before any clock edge.
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_a_valid", 16'(a_valid), 16'h1);
        chk("pre_rst_a_d", 16'(a_d), 16'h5A);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle -> A %0b/%02h B %0b/%02h", a_valid, a_d, b_valid, b_d);
        chk("async_rst_a_valid", 16'(a_valid), 16'h0);
        chk("async_rst_a_d", 16'(a_d), 16'h00);
        chk("async_rst_b_valid", 16'(b_valid), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef DEMUX_CNT_EN
        chk("cnt_reset_a", 16'(a_cnt), 16'h0);
        chk("cnt_reset_b", 16'(b_cnt), 16'h0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b1, 1'b1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        $display("counters after 17 words on A: A_Cnt=%0d B_Cnt=%0d", a_cnt, b_cnt);
        chk("cnt_wrap_a", 16'(a_cnt), 16'd1);
        chk("cnt_wrap_b", 16'(b_cnt), 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
